adder_op_sequencer: RTL and testbench
=====================================

Name: adder_op_sequencer

Overview:
- Sequential front-end for the 32-bit ripple-carry adder with N/Z/C/O flags.
- Accepts an arithmetic request (ADD/SUB/ADC/SBC) over a valid/ready handshake and drives registered operands and carry-in into the adder.
- Waits a programmable number of cycles for the ripple chain to settle, then captures the sum and produces registered N/Z/C/O flags.
- Holds a persistent carry flag so multi-word add/subtract chains can be built.

Parameters:
SETTLE_CYCLES, 4, cycles from operand launch to result capture; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request.
in_a  input  32  operand A.
in_b  input  32  operand B.
in_op  input  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
add_a  output  32  adder operand A (registered).
add_b  output  32  adder operand B, effective value (registered).
add_cin  output  1  adder carry-in (registered).
add_s  input  32  adder sum.
add_cout  input  1  adder carry-out.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_result  output  32  captured sum.
out_n  output  1  result negative (bit 31).
out_z  output  1  result equals zero.
out_c  output  1  carry-out.
out_o  output  1  signed overflow.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values (rst_n low at an edge): state IDLE; in_ready=1; every other output 0; internal carry flag cf=0; settle counter 0.
- Reset mid-operation: aborts the operation from any state. No result is produced and cf is cleared.
- States: IDLE, SETTLE, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE, accept edge (in_valid=1):
  - add_a <= in_a.
  - add_b <= in_b for ADD/ADC; add_b <= ~in_b for SUB/SBC.
  - add_cin <= 0 for ADD, 1 for SUB, cf for ADC and SBC.
  - cnt <= SETTLE_CYCLES-1; state -> SETTLE.
- IDLE with in_valid=0: stays in IDLE.
- SETTLE:
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0, capture and go to DONE:
    - out_result <= add_s; out_n <= add_s[31]; out_z <= (add_s == 0).
    - out_c <= add_cout; cf <= add_cout.
    - out_o <= (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]), using the effective add_b.
- Latency: out_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- DONE:
  - All out_* held stable while out_ready=0.
  - At an edge with out_ready=1: out_valid <= 0, state -> IDLE. in_ready returns to 1 that same cycle.
- Operand stability: add_a, add_b and add_cin are held constant from the accept edge until the next accept. They are never changed in SETTLE or DONE.
- No request overlap: in_valid is ignored outside IDLE. Any request pending there is neither consumed nor lost; the requester keeps it asserted.
- Carry convention: C=1 on subtract means no borrow. cf is written only at capture and persists across IDLE.
- Z is derived inside this block from all 32 add_s bits. It does not depend on the adder's own zero flag.
- Simultaneous events: rst_n low overrides everything. A DONE handshake edge and a new in_valid cannot both be accepted in the same cycle; the new request is taken on the following cycle, when state is IDLE.

Test Plan (SETTLE_CYCLES=4):
1. ADD 0x00000001 + 0x00000001 -> add_cin=0; out_valid rises 4 edges after accept; result 0x00000002; N,Z,C,O = 0,0,0,0.
2. SUB 0x00000000 - 0x00000001 -> add_b=0xFFFFFFFE, add_cin=1; result 0xFFFFFFFF; N=1, Z=0, C=0, O=0.
3. ADD 0x00000003 + 0xFFFFFFFF -> result 0x00000002, C=1. Then ADC 0 + 0 -> add_cin=1, result 0x00000001, C=0, cf=0.
4. ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000, N=1, O=1. Then SUB 5 - 5 -> 0x00000000, Z=1, C=1, O=0.
5. Backpressure: hold out_ready=0 for 3 cycles after out_valid while in_valid=1 -> out_* and add_* unchanged, in_ready=0. Raise out_ready -> IDLE next cycle, then the new request is accepted.
6. Set cf=1 via scenario 3's first op, then pull rst_n low during SETTLE of a second op -> next cycle state IDLE, all outputs 0, in_ready=1. A following ADC 0 + 0 -> add_cin=0, result 0x00000000, Z=1.

Source files
------------

// File: rtl/adder_op_sequencer_if.sv
// Request, result and adder-side signals of the adder op sequencer.
// The sequencer uses slave; the requester/adder side uses master.
interface adder_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_s;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_n;
  logic        out_z;
  logic        out_c;
  logic        out_o;

  modport slave (
    input  in_valid, in_a, in_b, in_op,
    input  add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin,
    output out_valid, out_result,
    output out_n, out_z, out_c, out_o
  );

  modport master (
    output in_valid, in_a, in_b, in_op,
    output add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin,
    input  out_valid, out_result,
    input  out_n, out_z, out_c, out_o
  );
endinterface

// File: rtl/adder_op_sequencer.sv
// Sequencer in front of a 32-bit ripple adder: launches operands,
// waits for the chain to settle, captures sum and N/Z/C/O flags.
module adder_op_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_op_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT =
    4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       cf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      cf             <= 1'b0;
      bus.in_ready   <= 1'b1;
      bus.add_a      <= '0;
      bus.add_b      <= '0;
      bus.add_cin    <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_n      <= 1'b0;
      bus.out_z      <= 1'b0;
      bus.out_c      <= 1'b0;
      bus.out_o      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.add_a    <= bus.in_a;
            cnt          <= CNT_INIT;
            state        <= SETTLE;
            bus.in_ready <= 1'b0;
            // op[0] selects subtract, op[1] chains through cf
            bus.add_b <= bus.in_op[0] ? ~bus.in_b : bus.in_b;
            unique case (1'b1)
              bus.in_op[1]: bus.add_cin <= cf;
              default:      bus.add_cin <= bus.in_op[0];
            endcase
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.out_result <= bus.add_s;
            bus.out_n      <= bus.add_s[31];
            bus.out_z      <= (bus.add_s == 32'd0);
            bus.out_c      <= bus.add_cout;
            cf             <= bus.add_cout;
            bus.out_o      <=
              (bus.add_a[31] == bus.add_b[31]) &&
              (bus.add_s[31] != bus.add_a[31]);
            bus.out_valid  <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Directed bench for adder_op_sequencer with a behavioural
// ripple-adder model on the adder side.
module tb_adder_op_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   errors;

  adder_op_sequencer_if bus ();

  adder_op_sequencer #(
    .SETTLE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign {bus.add_cout, bus.add_s} =
    {1'b0, bus.add_a} + {1'b0, bus.add_b} +
    33'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] addb;
    logic        cin;
    logic [31:0] res;
    logic [3:0]  nzco;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic launch(input string name,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] addb,
                        input logic cin);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({name, " ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({name, " add_a"}, bus.add_a, a);
    chk({name, " add_b"}, bus.add_b, addb);
    chk({name, " add_cin"}, 32'(bus.add_cin),
        32'(cin));
  endtask

  task automatic await(input string name);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({name, " latency"}, lat, 32'd4);
  endtask

  task automatic result(input string name,
                        input logic [31:0] res,
                        input logic [3:0] nzco);
    chk({name, " result"}, bus.out_result, res);
    chk({name, " nzco"},
        32'({bus.out_n, bus.out_z,
             bus.out_c, bus.out_o}),
        32'(nzco));
  endtask

  task automatic consume(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, " valid drop"},
        32'(bus.out_valid), 32'd0);
    chk({name, " ready back"},
        32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string name,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] addb,
                        input logic cin,
                        input logic [31:0] res,
                        input logic [3:0] nzco);
    launch(name, op, a, b, addb, cin);
    await(name);
    result(name, res, nzco);
    consume(name);
  endtask

  initial begin
    tests = 0;
    errors = 0;
    vecs[0] = '{"add1", 2'b00, 32'h1, 32'h1,
                32'h1, 1'b0, 32'h2, 4'b0000};
    vecs[1] = '{"sub0m1", 2'b01, 32'h0, 32'h1,
                32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF,
                4'b1000};
    vecs[2] = '{"add_c", 2'b00, 32'h3, 32'hFFFFFFFF,
                32'hFFFFFFFF, 1'b0, 32'h2, 4'b0010};
    vecs[3] = '{"adc00", 2'b10, 32'h0, 32'h0,
                32'h0, 1'b1, 32'h1, 4'b0000};
    vecs[4] = '{"add_ovf", 2'b00, 32'h7FFFFFFF,
                32'h1, 32'h1, 1'b0, 32'h80000000,
                4'b1001};
    vecs[5] = '{"sub55", 2'b01, 32'h5, 32'h5,
                32'hFFFFFFFA, 1'b1, 32'h0, 4'b0110};
    vecs[6] = '{"sbc00", 2'b11, 32'h0, 32'h0,
                32'hFFFFFFFF, 1'b1, 32'h0, 4'b0110};
    vecs[7] = '{"sbc01", 2'b11, 32'h0, 32'h1,
                32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF,
                4'b1000};
    vecs[8] = '{"sub_ovf", 2'b01, 32'h80000000,
                32'h1, 32'hFFFFFFFE, 1'b1,
                32'h7FFFFFFF, 4'b0011};
    vecs[9] = '{"adc11", 2'b10, 32'h1, 32'h1,
                32'h1, 1'b1, 32'h3, 4'b0000};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst add_a", bus.add_a, 32'd0);
    chk("rst add_b", bus.add_b, 32'd0);
    chk("rst add_cin", 32'(bus.add_cin), 32'd0);
    chk("rst result", bus.out_result, 32'd0);
    chk("rst flags",
        32'({bus.out_n, bus.out_z,
             bus.out_c, bus.out_o}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a,
             vecs[i].b, vecs[i].addb, vecs[i].cin,
             vecs[i].res, vecs[i].nzco);
    end

    // backpressure with a pending request
    launch("bp", 2'b00, 32'd10, 32'd20,
           32'd20, 1'b0);
    await("bp");
    bus.in_valid = 1'b1;
    bus.in_op = 2'b00;
    bus.in_a = 32'd1;
    bus.in_b = 32'd2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 32'(bus.out_valid), 32'd1);
      chk("bp hold result", bus.out_result, 32'd30);
      chk("bp hold add_a", bus.add_a, 32'd10);
      chk("bp hold add_b", bus.add_b, 32'd20);
      chk("bp in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp idle ready", 32'(bus.in_ready), 32'd1);
    chk("bp idle valid", 32'(bus.out_valid), 32'd0);
    chk("bp not taken", bus.add_a, 32'd10);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp next add_a", bus.add_a, 32'd1);
    chk("bp next add_b", bus.add_b, 32'd2);
    await("bp2");
    result("bp2", 32'd3, 4'b0000);
    consume("bp2");

    // reset during SETTLE clears cf
    run_op("cf_set", 2'b00, 32'h3, 32'hFFFFFFFF,
           32'hFFFFFFFF, 1'b0, 32'h2, 4'b0010);
    launch("abort", 2'b10, 32'h5, 32'h6,
           32'h6, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort valid", 32'(bus.out_valid), 32'd0);
    chk("abort add_a", bus.add_a, 32'd0);
    chk("abort add_b", bus.add_b, 32'd0);
    chk("abort add_cin", 32'(bus.add_cin), 32'd0);
    chk("abort result", bus.out_result, 32'd0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort no result",
          32'(bus.out_valid), 32'd0);
    end
    run_op("adc_after", 2'b10, 32'h0, 32'h0,
           32'h0, 1'b0, 32'h0, 4'b0100);

    $display("[TB] %0d tests run, %0d failed",
             tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
